// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency single-port memory between the IF fetch port and the MEM load/store port
// Ports: Clk/Clrn (sync active-high reset); if_* fetch port; d_* data port;
// mem_* memory side; stall_if/stall_mem pipeline holds; conflict_cnt perf counter.
// Optional macro ARB_PERF_EN builds the saturating arbitration-loss counter.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 4
) (
    input  logic              Clk,
    input  logic              Clrn,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem,
    output logic [15:0]       conflict_cnt
);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
    localparam logic [CNT_W-1:0] LAT = CNT_W'(MEM_LAT);
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic we_q, we_d;
    logic issue, done;
    always_ff @(posedge Clk) begin
        if (Clrn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
        end
    end
    // Data port has fixed priority: it carries the older instruction.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        if (state_q == IDLE) begin
            if (d_req) begin
                state_d = BUSY_D;
                cnt_d   = LAT;
                addr_d  = d_addr;
                wdata_d = d_wdata;
                we_d    = d_we;
            end else if (if_req) begin
                state_d = BUSY_I;
                cnt_d   = LAT;
                addr_d  = if_addr;
                we_d    = 1'b0;
            end
        end else begin
            cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
            state_d = (cnt_q == '0) ? IDLE : state_q;
        end
    end
    // Issue is the first BUSY cycle (cnt still at MEM_LAT); completion is cnt == 0.
    always_comb begin
        issue     = (state_q != IDLE) && (cnt_q == LAT);
        done      = (state_q != IDLE) && (cnt_q == '0);
        if_gnt    = issue && (state_q == BUSY_I);
        d_gnt     = issue && (state_q == BUSY_D);
        if_valid  = done && (state_q == BUSY_I);
        d_valid   = done && (state_q == BUSY_D);
        if_rdata  = mem_rdata;
        d_rdata   = mem_rdata;
        mem_en    = issue;
        mem_we    = issue && we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        stall_if  = if_req && !if_valid;
        stall_mem = d_req && !d_valid;
    end
`ifdef ARB_PERF_EN
    logic [15:0] conflict_q, conflict_d;
    always_comb begin
        conflict_d = (state_q == IDLE && d_req && if_req && conflict_q != 16'hFFFF) ? conflict_q + 16'd1 : conflict_q;
    end
    always_ff @(posedge Clk) begin
        if (Clrn) conflict_q <= '0;
        else conflict_q <= conflict_d;
    end
    assign conflict_cnt = conflict_q;
`else
    assign conflict_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    localparam int L = 2;
    logic Clk = 1'b0, Clrn = 1'b1;
    logic if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
    logic if_gnt, if_valid, d_gnt, d_valid, mem_en, mem_we, stall_if, stall_mem;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic [15:0] conflict_cnt;
    logic [7:0] ctl;
    int n_cmp = 0, n_fail = 0, cyc = 0, rd_due = -100;
    logic [31:0] rd_addr;
    logic [31:0] env_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(L), .CNT_W(4)) dut (
        .Clk(Clk), .Clrn(Clrn),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem), .conflict_cnt(conflict_cnt)
    );

    assign ctl = {if_gnt, if_valid, d_gnt, d_valid, mem_en, mem_we, stall_if, stall_mem};
    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    function automatic logic [31:0] hsh(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction
    function automatic logic [31:0] env_rd(input logic [31:0] a);
        return env_mem.exists(a) ? env_mem[a] : hsh(a);
    endfunction
    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : hsh(a);
    endfunction

    // Memory emulation: answers MEM_LAT cycles after each strobe, garbage otherwise.
    initial begin
        env_mem[32'h40] = 32'h8C010004;
        forever begin
            @(posedge Clk);
            #1;
            mem_rdata = (cyc == rd_due) ? env_rd(rd_addr) : $urandom;
            @(negedge Clk);
            if (mem_en) begin
                rd_due  = cyc + L;
                rd_addr = mem_addr;
                if (mem_we) env_mem[mem_addr] = mem_wdata;
            end
        end
    end

    task automatic do_reset();
        @(posedge Clk);
        #1;
        Clrn = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        @(posedge Clk);
        #1;
        Clrn = 1'b0;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            @(posedge Clk);
            #1;
            @(negedge Clk);
            n_cmp++;
            if (ctl !== 8'h00 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 || conflict_cnt !== 16'h0) begin
                n_fail++;
                $display("FAIL reset c%0d: ctl=%b addr=%h wdata=%h conf=%h, want all 0", c, ctl, mem_addr, mem_wdata, conflict_cnt);
            end
        end
        @(posedge Clk);
        #1;
        Clrn = 1'b0;
    endtask

    task automatic test_fetch();
        logic [7:0] e;
        do_reset();
        if_req = 1'b1; if_addr = 32'h40;
        for (int c = 0; c < 5; c++) begin
            @(negedge Clk);
            e = {c == 1, c == 3, 1'b0, 1'b0, c == 1, 1'b0, c < 3, 1'b0};
            n_cmp++;
            if (ctl !== e) begin n_fail++; $display("FAIL fetch ctl c%0d: got %b want %b", c, ctl, e); end
            if (c >= 1) begin
                n_cmp++;
                if (mem_addr !== 32'h40) begin n_fail++; $display("FAIL fetch addr c%0d: got %h want 00000040", c, mem_addr); end
            end
            if (c == 3) begin
                n_cmp++;
                if (if_rdata !== 32'h8C010004) begin n_fail++; $display("FAIL fetch rdata: got %h want 8c010004", if_rdata); end
            end
            @(posedge Clk);
            #1;
            if (c == 3) if_req = 1'b0;
        end
    endtask

    task automatic test_store();
        logic [7:0] e;
        do_reset();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
        for (int c = 0; c < 5; c++) begin
            @(negedge Clk);
            e = {1'b0, 1'b0, c == 1, c == 3, c == 1, c == 1, 1'b0, c < 3};
            n_cmp++;
            if (ctl !== e) begin n_fail++; $display("FAIL store ctl c%0d: got %b want %b", c, ctl, e); end
            if (c >= 1) begin
                n_cmp++;
                if (mem_addr !== 32'h100 || mem_wdata !== 32'hDEADBEEF) begin
                    n_fail++;
                    $display("FAIL store bus c%0d: got %h/%h want 00000100/deadbeef", c, mem_addr, mem_wdata);
                end
            end
            @(posedge Clk);
            #1;
            if (c == 3) begin d_req = 1'b0; d_we = 1'b0; end
        end
    endtask

    task automatic test_conflict();
        logic [7:0] e;
        logic [15:0] ec;
        do_reset();
        if_req = 1'b1; if_addr = 32'h44; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h104;
        for (int c = 0; c < 9; c++) begin
            @(negedge Clk);
            e = {c == 5, c == 7, c == 1, c == 3, c == 1 || c == 5, 1'b0, c < 7, c < 3};
            n_cmp++;
            if (ctl !== e) begin n_fail++; $display("FAIL conflict ctl c%0d: got %b want %b", c, ctl, e); end
            if (c == 3) begin
                n_cmp++;
                if (d_rdata !== hsh(32'h104)) begin n_fail++; $display("FAIL conflict d_rdata: got %h want %h", d_rdata, hsh(32'h104)); end
            end
            if (c == 7) begin
                n_cmp++;
                if (if_rdata !== hsh(32'h44)) begin n_fail++; $display("FAIL conflict if_rdata: got %h want %h", if_rdata, hsh(32'h44)); end
            end
`ifdef ARB_PERF_EN
            ec = (c >= 1) ? 16'd1 : 16'd0;
`else
            ec = 16'd0;
`endif
            n_cmp++;
            if (conflict_cnt !== ec) begin n_fail++; $display("FAIL conflict cnt c%0d: got %h want %h", c, conflict_cnt, ec); end
            @(posedge Clk);
            #1;
            if (c == 3) d_req = 1'b0;
            if (c == 7) if_req = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        if_req = 1'b1; if_addr = 32'h80;
        for (int c = 0; c < 9; c++) begin
            @(negedge Clk);
            if (c == 1) begin
                n_cmp++;
                if (if_gnt !== 1'b1) begin n_fail++; $display("FAIL rstmid gnt1: got %b want 1", if_gnt); end
            end
            if (c == 2 || c == 3) begin
                n_cmp++;
                if (if_valid !== 1'b0 || mem_en !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rstmid quiet c%0d: valid=%b en=%b want 0/0", c, if_valid, mem_en);
                end
            end
            if (c == 3) begin
                n_cmp++;
                if (ctl !== 8'h00 || mem_addr !== 32'h0) begin n_fail++; $display("FAIL rstmid cleared: ctl=%b addr=%h want 0", ctl, mem_addr); end
            end
            if (c == 4) begin
                n_cmp++;
                if (if_gnt !== 1'b0 || stall_if !== 1'b1) begin n_fail++; $display("FAIL rstmid rereq: gnt=%b stall=%b want 0/1", if_gnt, stall_if); end
            end
            if (c == 5) begin
                n_cmp++;
                if (if_gnt !== 1'b1 || mem_addr !== 32'h84) begin n_fail++; $display("FAIL rstmid gnt5: gnt=%b addr=%h want 1/00000084", if_gnt, mem_addr); end
            end
            if (c == 7) begin
                n_cmp++;
                if (if_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid valid7: got %b want 1", if_valid); end
            end
            @(posedge Clk);
            #1;
            if (c == 1) begin Clrn = 1'b1; if_req = 1'b0; end
            if (c == 2) Clrn = 1'b0;
            if (c == 3) begin if_req = 1'b1; if_addr = 32'h84; end
            if (c == 7) if_req = 1'b0;
        end
    endtask

    task automatic test_perf_sat();
        logic [15:0] ec;
        do_reset();
        @(negedge Clk);
`ifdef ARB_PERF_EN
        dut.conflict_q = 16'hFFFE;
`endif
        @(posedge Clk);
        #1;
        if_req = 1'b1; if_addr = 32'h48; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h108;
        for (int c = 0; c < 3 * (L + 3) + 2; c++) begin
            @(negedge Clk);
`ifdef ARB_PERF_EN
            ec = (c >= 1) ? 16'hFFFF : 16'hFFFE;
`else
            ec = 16'h0000;
`endif
            n_cmp++;
            if (conflict_cnt !== ec) begin n_fail++; $display("FAIL perf sat c%0d: got %h want %h", c, conflict_cnt, ec); end
        end
        @(posedge Clk);
        #1;
        if_req = 1'b0; d_req = 1'b0;
        repeat (L + 3) @(posedge Clk);
        #1;
    endtask

    task automatic test_random();
        logic m_busy = 1'b0, m_isd = 1'b0, m_we = 1'b0, ev_i, ev_d, iss;
        int m_issue = 0, m_done = 0;
        logic [31:0] m_addr = '0, m_wd = '0, m_rd = '0;
        logic [15:0] m_conf = '0, ec;
        logic [7:0] e;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            @(negedge Clk);
            iss  = m_busy && cyc == m_issue;
            ev_i = m_busy && !m_isd && cyc == m_done;
            ev_d = m_busy && m_isd && cyc == m_done;
            e = {iss && !m_isd, ev_i, iss && m_isd, ev_d, iss, iss && m_we, if_req && !ev_i, d_req && !ev_d};
            n_cmp++;
            if (ctl !== e) begin n_fail++; $display("FAIL rand ctl cyc%0d: got %b want %b", cyc, ctl, e); end
            n_cmp++;
            if (mem_addr !== m_addr || mem_wdata !== m_wd) begin
                n_fail++;
                $display("FAIL rand bus cyc%0d: got %h/%h want %h/%h", cyc, mem_addr, mem_wdata, m_addr, m_wd);
            end
`ifdef ARB_PERF_EN
            ec = m_conf;
`else
            ec = 16'h0000;
`endif
            n_cmp++;
            if (conflict_cnt !== ec) begin n_fail++; $display("FAIL rand conf cyc%0d: got %h want %h", cyc, conflict_cnt, ec); end
            if (ev_i) begin
                n_cmp++;
                if (if_rdata !== m_rd) begin n_fail++; $display("FAIL rand if_rdata cyc%0d: got %h want %h", cyc, if_rdata, m_rd); end
            end
            if (ev_d && !m_we) begin
                n_cmp++;
                if (d_rdata !== m_rd) begin n_fail++; $display("FAIL rand d_rdata cyc%0d: got %h want %h", cyc, d_rdata, m_rd); end
            end
            if (m_busy) begin
                if (cyc == m_done) m_busy = 1'b0;
            end else if (d_req || if_req) begin
                if (d_req && if_req && m_conf != 16'hFFFF) m_conf = m_conf + 16'd1;
                m_isd   = d_req;
                m_busy  = 1'b1;
                m_issue = cyc + 1;
                m_done  = cyc + 1 + L;
                m_addr  = d_req ? d_addr : if_addr;
                m_we    = d_req && d_we;
                if (d_req) m_wd = d_wdata;
                if (m_we) ref_mem[m_addr] = d_wdata;
                else m_rd = ref_rd(m_addr);
            end
            @(posedge Clk);
            #1;
            if (!if_req || ev_i) begin
                if_req  = $urandom_range(0, 2) != 0;
                if_addr = 32'h200 + 32'($urandom_range(0, 15) << 2);
            end
            if (!d_req || ev_d) begin
                d_req   = $urandom_range(0, 2) != 0;
                d_we    = $urandom_range(0, 1) != 0;
                d_addr  = 32'h200 + 32'($urandom_range(0, 15) << 2);
                d_wdata = $urandom;
            end
        end
        if_req = 1'b0; d_req = 1'b0;
        repeat (L + 3) @(posedge Clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_conflict();
        test_reset_mid();
        test_perf_sat();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
